// File: rtl/user_trap_controller.sv
// Trap sequencer for the user-mode CPU: arbitrates exceptions, interrupts and
// uret, then drives ucause/uepc/ustatus writes and the PC redirect in turn.
module user_trap_controller #(
    parameter bit VECTORED_EN  = 1'b1,
    parameter bit EXT_IRQ_EDGE = 1'b1
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iValid,
    input  logic [31:0] iPC,
    input  logic        iIllegal,
    input  logic        iEbreak,
    input  logic        iEcall,
    input  logic        iLoadMis,
    input  logic        iStoreMis,
    input  logic        iUret,
    input  logic        iExtIrq,
    input  logic        iTimerIrq,
    input  logic [31:0] iUSTATUS,
    input  logic [31:0] iUIE,
    input  logic [31:0] iUTVEC,
    input  logic [31:0] iUEPC,
    output logic        oUCAUSEWrite,
    output logic        oUEPCWrite,
    output logic [31:0] oUCAUSEData,
    output logic [31:0] oUEPCData,
    output logic        oCSRWrite,
    output logic [6:0]  oCSRAddr,
    output logic [31:0] oCSRData,
    output logic        oStall,
    output logic        oRedirect,
    output logic [31:0] oRedirectPC,
    output logic [2:0]  oDbgState
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T_CAUSE  = 3'd1,
        T_STATUS = 3'd2,
        T_JUMP   = 3'd3,
        R_STATUS = 3'd4,
        R_JUMP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cause_q, epc_q, target_q;
    logic        ext_pend_q, ext_prev_q;

    logic        exc_any, exc_take, uret_take, irq_ok, ext_req, ext_take, tim_take;
    logic        trap_go;
    logic [3:0]  exc_code, irq_code;
    logic [31:0] cause_d, epc_d, target_d, tvec_base;

    logic unused_uie;
    assign unused_uie = ^{iUIE[31:9], iUIE[7:5], iUIE[3:0]};

    // Decision logic; only meaningful while IDLE.
    always_comb begin
        exc_any   = iIllegal | iEbreak | iEcall | iLoadMis | iStoreMis;
        exc_take  = iValid & exc_any;
        uret_take = iValid & iUret & ~exc_any;
        irq_ok    = ~exc_take & ~uret_take & iUSTATUS[0];
        ext_req   = EXT_IRQ_EDGE ? ext_pend_q : iExtIrq;
        ext_take  = irq_ok & ext_req & iUIE[8];
        tim_take  = irq_ok & iTimerIrq & iUIE[4] & ~ext_take;
        trap_go   = (state_q == IDLE) & (exc_take | ext_take | tim_take);

        if (iIllegal)      exc_code = 4'd2;
        else if (iEbreak)  exc_code = 4'd3;
        else if (iEcall)   exc_code = 4'd8;
        else if (iLoadMis) exc_code = 4'd4;
        else               exc_code = 4'd6;

        irq_code  = ext_take ? 4'd8 : 4'd4;
        tvec_base = {iUTVEC[31:2], 2'b00};

        if (exc_take) begin
            cause_d  = {28'd0, exc_code};
            epc_d    = iPC;
            target_d = tvec_base;
        end else begin
            cause_d  = {1'b1, 27'd0, irq_code};
            // The CSR file adds 4 on write, so the interrupted PC is reloaded.
            epc_d    = iPC - 32'd4;
            target_d = (VECTORED_EN && iUTVEC[1:0] == 2'b01)
                     ? tvec_base + {26'd0, irq_code, 2'b00} : tvec_base;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (exc_take | ext_take | tim_take) state_d = T_CAUSE;
                else if (uret_take)                 state_d = R_STATUS;
            end
            T_CAUSE:  state_d = T_STATUS;
            T_STATUS: state_d = T_JUMP;
            T_JUMP:   state_d = IDLE;
            R_STATUS: state_d = R_JUMP;
            R_JUMP:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
            target_q <= 32'd0;
        end else if (trap_go) begin
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            target_q <= target_d;
        end
    end

    // Edge latch: holds until the external interrupt is actually taken.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ext_prev_q <= 1'b0;
            ext_pend_q <= 1'b0;
        end else begin
            ext_prev_q <= iExtIrq;
            if (trap_go && ext_take)       ext_pend_q <= 1'b0;
            else if (iExtIrq && !ext_prev_q) ext_pend_q <= 1'b1;
        end
    end

    always_comb begin
        oUCAUSEWrite = 1'b0;
        oUEPCWrite   = 1'b0;
        oUCAUSEData  = 32'd0;
        oUEPCData    = 32'd0;
        oCSRWrite    = 1'b0;
        oCSRAddr     = 7'd64;
        oCSRData     = 32'd0;
        oRedirect    = 1'b0;
        oRedirectPC  = 32'd0;
        oStall       = (state_q != IDLE);
        oDbgState    = state_q;
        case (state_q)
            T_CAUSE: begin
                oUCAUSEWrite = 1'b1;
                oUCAUSEData  = cause_q;
                oUEPCWrite   = 1'b1;
                oUEPCData    = epc_q;
            end
            T_STATUS: begin
                oCSRWrite = 1'b1;
                oCSRData  = {iUSTATUS[31:5], iUSTATUS[0], iUSTATUS[3:1], 1'b0};
            end
            T_JUMP: begin
                oRedirect   = 1'b1;
                oRedirectPC = target_q;
            end
            R_STATUS: begin
                oCSRWrite = 1'b1;
                oCSRData  = {iUSTATUS[31:5], 1'b1, iUSTATUS[3:1], iUSTATUS[4]};
            end
            R_JUMP: begin
                oRedirect   = 1'b1;
                oRedirectPC = iUEPC;
            end
            default: ;
        endcase
    end

endmodule
